// File: rtl/light_pkg.sv
// Shared light-path definitions: level codes and fader FSM states.
package light_pkg;

    localparam logic [1:0] LIGHT_OFF  = 2'b00;
    localparam logic [1:0] LIGHT_LOW  = 2'b01;
    localparam logic [1:0] LIGHT_MID  = 2'b10;
    localparam logic [1:0] LIGHT_HIGH = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } fade_state_t;

endpackage

// File: rtl/light_pwm_fader_pwm_gen.sv
// PWM generator: free-running counter, period-aligned shadow duty,
// registered compare output.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] CNT_MAX =
        PWM_BITS'((1 << PWM_BITS) - 2);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] eff;

    // At the wrap the fresh duty is used so the whole period sees one value.
    assign eff = (cnt == '0) ? duty : shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            if (cnt == '0)
                shadow <= duty;
            pwm <= (cnt < eff);
        end
    end

endmodule

// File: rtl/light_pwm_fader.sv
// Light level to PWM LED drive, with optional duty ramping.
// Define LIGHT_FADE_EN to compile in the prescaler and ramp FSM.
module light_pwm_fader
    import light_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 100000,
    parameter int DUTY_L1  = 64,
    parameter int DUTY_L2  = 160,
    parameter int DUTY_L3  = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [1:0]          i_light,
    output logic                o_led,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_busy
);

    if (FADE_DIV < 1) begin : g_bad_div
        $error("FADE_DIV must be at least 1");
    end

    logic [1:0]          r_light;
    logic [PWM_BITS-1:0] target;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_light <= LIGHT_OFF;
        else
            r_light <= i_light;
    end

    always_comb begin
        target = '0;
        unique case (r_light)
            LIGHT_OFF:  target = '0;
            LIGHT_LOW:  target = PWM_BITS'(DUTY_L1);
            LIGHT_MID:  target = PWM_BITS'(DUTY_L2);
            LIGHT_HIGH: target = PWM_BITS'(DUTY_L3);
        endcase
    end

`ifdef LIGHT_FADE_EN
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(FADE_DIV - 1);

    fade_state_t         state;
    fade_state_t         state_nxt;
    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] target_q;
    logic [PWM_BITS-1:0] level_nxt;
    logic                target_chg;
    logic                step;

    // A new target restarts the step interval from the current level.
    assign target_chg = (target != target_q);
    assign step = (state != IDLE) && !target_chg && (presc == PRE_MAX);

    always_comb begin
        level_nxt = o_level;
        state_nxt = IDLE;
        unique case (1'b1)
            step && (state == RAMP_UP):   level_nxt = o_level + 1'b1;
            step && (state == RAMP_DOWN): level_nxt = o_level - 1'b1;
            default:                      level_nxt = o_level;
        endcase
        if (target > level_nxt)
            state_nxt = RAMP_UP;
        else if (target < level_nxt)
            state_nxt = RAMP_DOWN;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            presc    <= '0;
            target_q <= '0;
            o_level  <= '0;
        end else begin
            state    <= state_nxt;
            o_level  <= level_nxt;
            target_q <= target;
            if (state == IDLE || target_chg || presc == PRE_MAX)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

    assign o_busy = (state != IDLE);
`else
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_level <= '0;
        else
            o_level <= target;
    end

    assign o_busy = 1'b0;
`endif

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk   (i_clk),
        .reset (i_reset),
        .duty  (o_level),
        .pwm   (o_led)
    );

endmodule
